// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: walks CHUNK-bit slices from the MSB down, signed or unsigned.
// Optional CMP_EARLY_EXIT_EN: finish as soon as the first differing chunk is seen.
module seq_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_op_1,
  input  logic [WIDTH-1:0]     i_op_2,
  input  logic                 i_signed,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 gt,
  output logic                 eq,
  output logic                 lt,
  output logic [(((WIDTH/CHUNK) > 1) ? $clog2(WIDTH/CHUNK) : 1)-1:0] o_diff_idx
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ready;
  logic              r_valid;
  logic [WIDTH-1:0]  r_op1;
  logic [WIDTH-1:0]  r_op2;
  logic [IDXW-1:0]   r_k;
  logic              r_found;
  logic              r_gt_acc;
  logic              r_lt_acc;
  logic [IDXW-1:0]   r_idx_acc;

  logic [CHUNK-1:0]  w_c1;
  logic [CHUNK-1:0]  w_c2;
  logic              w_diff;
  logic              w_hit;
  logic              w_exit;
  logic              w_found_nxt;
  logic              w_gt_nxt;
  logic              w_lt_nxt;
  logic [IDXW-1:0]   w_idx_nxt;
  logic [WIDTH-1:0]  w_bias;

  assign o_ready = r_ready;
  assign o_valid = r_valid;

  // Flipping the sign bit maps two's-complement ordering onto unsigned ordering
  assign w_bias = {i_signed, {(WIDTH-1){1'b0}}};

  assign w_c1 = r_op1[32'(r_k)*CHUNK +: CHUNK];
  assign w_c2 = r_op2[32'(r_k)*CHUNK +: CHUNK];

  // State register; handshake flags are registered copies of the next-state decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE);
      r_valid <= (w_state_nxt == DONE);
    end
  end

  // Next-state and per-chunk compare
  always_comb begin
    w_state_nxt = r_state;
    w_diff      = (w_c1 != w_c2);
    w_hit       = w_diff && !r_found;
    w_found_nxt = r_found | w_diff;
    w_gt_nxt    = r_gt_acc;
    w_lt_nxt    = r_lt_acc;
    w_idx_nxt   = r_idx_acc;
`ifdef CMP_EARLY_EXIT_EN
    w_exit      = (r_k == '0) || w_hit;
`else
    w_exit      = (r_k == '0);
`endif
    if (w_hit) begin
      w_gt_nxt  = (w_c1 > w_c2);
      w_lt_nxt  = (w_c1 < w_c2);
      w_idx_nxt = r_k;
    end
    case (r_state)
      IDLE:    if (i_valid) w_state_nxt = RUN;
      RUN:     if (w_exit)  w_state_nxt = DONE;
      DONE:    if (i_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand capture, running result, and result registers loaded on leaving RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_k        <= '0;
      r_found    <= 1'b0;
      r_gt_acc   <= 1'b0;
      r_lt_acc   <= 1'b0;
      r_idx_acc  <= '0;
      gt         <= 1'b0;
      eq         <= 1'b0;
      lt         <= 1'b0;
      o_diff_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_op1     <= i_op_1 ^ w_bias;
            r_op2     <= i_op_2 ^ w_bias;
            r_k       <= IDXW'(NCHUNK - 1);
            r_found   <= 1'b0;
            r_gt_acc  <= 1'b0;
            r_lt_acc  <= 1'b0;
            r_idx_acc <= '0;
          end
        end
        RUN: begin
          r_found   <= w_found_nxt;
          r_gt_acc  <= w_gt_nxt;
          r_lt_acc  <= w_lt_nxt;
          r_idx_acc <= w_idx_nxt;
          if (w_exit) begin
            gt         <= w_gt_nxt;
            lt         <= w_lt_nxt;
            eq         <= !w_found_nxt;
            o_diff_idx <= w_idx_nxt;
          end else begin
            r_k <= r_k - IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_comparator.sv
// Scoreboard bench for seq_comparator (WIDTH=32, CHUNK=8); expected latency follows CMP_EARLY_EXIT_EN.
module tb_seq_comparator;

  localparam int unsigned W = 32;
  localparam int unsigned C = 8;
  localparam int unsigned N = W / C;
`ifdef CMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct packed {
    logic        gt;
    logic        eq;
    logic        lt;
    logic [1:0]  idx;
    logic [31:0] lat;
    logic [31:0] acc;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_op_1;
  logic [W-1:0]  i_op_2;
  logic          i_signed;
  logic          o_valid;
  logic          i_ready;
  logic          gt;
  logic          eq;
  logic          lt;
  logic [1:0]    o_diff_idx;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic          prev_v = 1'b0;
  int unsigned   cyc = 0;
  int unsigned   last_acc;
  int unsigned   checks = 0;
  int unsigned   errors = 0;

  seq_comparator #(.WIDTH(W), .CHUNK(C)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op_1     (i_op_1),
    .i_op_2     (i_op_2),
    .i_signed   (i_signed),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .gt         (gt),
    .eq         (eq),
    .lt         (lt),
    .o_diff_idx (o_diff_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each new result is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (o_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 expected no result (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("gt", 32'(gt), 32'(mon_e.gt));
        chk("eq", 32'(eq), 32'(mon_e.eq));
        chk("lt", 32'(lt), 32'(mon_e.lt));
        chk("diff_idx", 32'(o_diff_idx), 32'(mon_e.idx));
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
    prev_v = o_valid;
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t m;
    m = '0;
    m.gt = s ? ($signed(a) > $signed(b)) : (a > b);
    m.lt = s ? ($signed(a) < $signed(b)) : (a < b);
    m.eq = (a == b);
    for (int i = 0; i < int'(N); i++)
      if (a[i*C +: C] != b[i*C +: C]) m.idx = 2'(i);
    m.lat = m.eq ? N : (N - 32'(m.idx));
    return m;
  endfunction

  // Called at a negedge; returns at the first negedge with o_ready high
  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_valid) chk("valid_timeout", 32'(o_valid), 32'd1);
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic egt, input logic eeq, input logic elt,
                      input logic [1:0] eidx, input int unsigned lat_e, input bit push);
    exp_t e;
    wait_ready();
    i_op_1 = a; i_op_2 = b; i_signed = s; i_valid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (push) begin
      e.gt = egt; e.eq = eeq; e.lt = elt; e.idx = eidx;
      e.lat = EE ? lat_e : N;
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    i_valid  = 1'b0;
    i_op_1   = $urandom;
    i_op_2   = $urandom;
    i_signed = ~s;
  endtask

  initial begin
    exp_t        m;
    int unsigned prev_acc;
    int unsigned prev_lat;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic        vs [3];

    rst_n = 1'b0; i_valid = 1'b0; i_op_1 = '0; i_op_2 = '0; i_signed = 1'b0; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_flags", {29'd0, gt, eq, lt}, 32'd0);
    chk("rst_idx", 32'(o_diff_idx), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results; lat_e is the early-exit latency
    send(32'd5, 32'd0, 1'b0, 1, 0, 0, 2'd0, 4, 1);
    send(32'hFFFF_FFFA, 32'h0000_0005, 1'b1, 0, 0, 1, 2'd3, 1, 1);
    send(32'hFFFF_FFFA, 32'h0000_0005, 1'b0, 1, 0, 0, 2'd3, 1, 1);
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 0, 1, 0, 2'd0, 4, 1);

    // Backpressure: result must hold and new requests be ignored
    wait_ready();
    i_ready = 1'b0;
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 0, 1, 2'd3, 1, 1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_op_1 = $urandom; i_op_2 = $urandom; i_signed = i[0];
      @(negedge clk);
      chk("bp_valid", 32'(o_valid), 32'd1);
      chk("bp_ready", 32'(o_ready), 32'd0);
      chk("bp_flags", {29'd0, gt, eq, lt}, 32'b001);
      chk("bp_idx", 32'(o_diff_idx), 32'd3);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_after", 32'(o_ready), 32'd1);
    chk("bp_valid_after", 32'(o_valid), 32'd0);
    chk("idle_hold_lt", 32'(lt), 32'd1);
    send(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1, 0, 0, 2'd3, 1, 1);

    // Reset during the second RUN cycle aborts the compare
    send(32'd5, 32'd0, 1'b0, 1, 0, 0, 2'd0, 4, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(o_ready), 32'd1);
    chk("abort_valid", 32'(o_valid), 32'd0);
    chk("abort_flags", {29'd0, gt, eq, lt}, 32'd0);
    chk("abort_idx", 32'(o_diff_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd5, 32'd0, 1'b0, 1, 0, 0, 2'd0, 4, 1);

    // Back-to-back against the software model; spacing must be latency + 2
    va[0] = 32'h0000_0100; vb[0] = 32'h0000_00FF; vs[0] = 1'b0;
    va[1] = 32'h8000_0001; vb[1] = 32'h8000_0001; vs[1] = 1'b1;
    va[2] = 32'h0102_0304; vb[2] = 32'h7F00_0000; vs[2] = 1'b1;
    prev_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < 3; i++) begin
      m = model(va[i], vb[i], vs[i]);
      send(va[i], vb[i], vs[i], m.gt, m.eq, m.lt, m.idx, m.lat, 1);
      if (i > 0) chk("b2b_spacing", last_acc - prev_acc, prev_lat + 2);
      prev_acc = last_acc;
      prev_lat = EE ? m.lat : N;
    end

    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
